vn_sum_sequencer: RTL and testbench
===================================

Name: vn_sum_sequencer

Overview:
Serial variable-node sum sequencer for the LDPC decoder. Takes one signed channel LLR and a column degree, then pulls that many check-to-variable messages one per handshake. It folds each message into a running total through a single N-bit signed saturating adder, reused every cycle. It presents the final saturated sum on a valid/ready output. It sits between the message memory read port and the variable-node update/write-back stage.

Parameters:
N, 7, message/LLR width, two's complement.
DMAX, 4, maximum column degree (number of check messages per sum).
CW, $clog2(DMAX+1), width of the degree input.

Ports:
i_clk  input  1  clock; all logic on rising edge.
i_rst_n  input  1  synchronous active-low reset.
i_start  input  1  start request; sampled only in IDLE.
i_llr  input  N  signed channel LLR, captured with i_start.
i_deg  input  CW  number of messages to add (0..DMAX), captured with i_start.
i_msg_valid  input  1  message available.
i_msg  input  N  signed check-to-variable message.
o_msg_ready  output  1  sequencer accepts i_msg this cycle.
o_sum_valid  output  1  o_sum holds the final result.
o_sum  output  N  signed saturated sum.
i_sum_ready  input  1  downstream accepts o_sum.
o_sat  output  1  at least one add saturated during this operation.
o_busy  output  1  high in ACC or OUT.

Behaviour:
- Reset: clock and reset are synchronous, active-low. While i_rst_n=0 at a clock edge: state=IDLE; acc=0; remaining=0; o_sum=0; o_sum_valid=0; o_msg_ready=0; o_sat=0; o_busy=0.
- Saturating add: sat(a,b) = a+b computed at N+1 bits.
  - Result > 2^(N-1)-1 clamps to 2^(N-1)-1.
  - Result < -2^(N-1) clamps to -2^(N-1).
  - Clamping is applied per step, not once on the final total; this is order-dependent by design.
- IDLE:
  - o_busy=0, o_msg_ready=0, o_sum_valid=0.
  - On i_start=1: acc<=i_llr; o_sat<=0; remaining<=min(i_deg,DMAX), so i_deg>DMAX is treated as DMAX.
  - Next state is OUT if the captured degree is 0, else ACC.
- ACC:
  - o_msg_ready=1, o_busy=1.
  - On each cycle with i_msg_valid=1: acc<=sat(acc,i_msg); o_sat<=o_sat|overflow; remaining<=remaining-1.
  - On the handshake with remaining==1, go to OUT.
  - A cycle without i_msg_valid holds all state.
- OUT:
  - o_sum_valid=1, o_sum=acc, o_msg_ready=0, o_busy=1.
  - o_sum and o_sat stay stable until i_sum_ready=1, then go to IDLE.
- o_sat remains readable in IDLE until the next i_start.
- i_start while not in IDLE is ignored and is not queued. A start coincident with the output handshake is also ignored; the requester re-asserts it in IDLE.
- Latency, start sample at cycle 0 with i_msg_valid held high: o_sum_valid asserts at cycle deg+1 (cycle 1 for deg=0). Throughput is one operation per deg+2 cycles with i_sum_ready held high.
- Reset mid-operation: the operation is abandoned, no output is produced, and the FSM returns to IDLE with reset values.
- o_sum updates only on entry to OUT; it is not a live view of acc.

Optional Feature:
SAT_COUNT_EN:
- Defined: adds output o_sat_cnt [15:0], a count of clamped add steps since reset. It increments once per saturating step (including steps within the same operation), saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
1. llr=10, deg=3, msgs 5,-3,20 back-to-back, i_sum_ready=1 -> o_sum_valid at cycle 4, o_sum=32, o_sat=0.
2. llr=60, deg=2, msgs 10,-10 -> first step clamps to 63, final o_sum=53 (not 60), o_sat=1.
3. llr=-60, deg=1, msg -10 -> o_sum=-64, o_sat=1; with SAT_COUNT_EN, o_sat_cnt increments by 1.
4. llr=-7, deg=0 -> o_sum_valid at cycle 1, o_sum=-7, o_msg_ready never asserted.
5. deg=2, msgs with a 3-cycle i_msg_valid gap, i_sum_ready low for 5 cycles, i_start pulsed during ACC and OUT -> o_msg_ready stays 1 through the gap, o_sum held stable, both starts ignored, result correct.
6. deg=3, reset asserted after 1 message accepted -> next cycle all outputs 0 and state IDLE; a following op llr=1, deg=1, msg 2 -> o_sum=3.

Source files
------------

// File: rtl/vn_sum_if.sv
// Handshake bundle between the message memory, the vn_sum_sequencer and the write-back stage.
// The sat_cnt member exists only when SAT_COUNT_EN is defined.
interface vn_sum_if #(
  parameter int N    = 7,
  parameter int DMAX = 4,
  parameter int CW   = $clog2(DMAX + 1)
);
  logic          start;
  logic [N-1:0]  llr;
  logic [CW-1:0] deg;
  logic          msg_valid;
  logic [N-1:0]  msg;
  logic          msg_ready;
  logic          sum_valid;
  logic [N-1:0]  sum;
  logic          sum_ready;
  logic          sat;
  logic          busy;
`ifdef SAT_COUNT_EN
  logic [15:0]   sat_cnt;
`endif

  modport master (
`ifdef SAT_COUNT_EN
    input  sat_cnt,
`endif
    output start, llr, deg, msg_valid, msg, sum_ready,
    input  msg_ready, sum_valid, sum, sat, busy
  );

  modport slave (
`ifdef SAT_COUNT_EN
    output sat_cnt,
`endif
    input  start, llr, deg, msg_valid, msg, sum_ready,
    output msg_ready, sum_valid, sum, sat, busy
  );
endinterface

// File: rtl/vn_sum_sequencer.sv
// Serial variable-node sum: channel LLR plus up to DMAX check messages through one saturating adder.
// Optional saturation-event counter enabled by defining SAT_COUNT_EN.
module vn_sum_sequencer #(
  parameter int N    = 7,
  parameter int DMAX = 4,
  parameter int CW   = $clog2(DMAX + 1)
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  vn_sum_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Two's complement add at N+1 bits, clamped to the N-bit range; MSB of the result flags a clamp.
  function automatic logic [N:0] sat_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0]   wide;
    logic [N-1:0] res;
    logic         ovf;
    wide = {a[N-1], a} + {b[N-1], b};
    ovf  = wide[N] ^ wide[N-1];
    if (!ovf) begin
      res = wide[N-1:0];
    end else if (wide[N]) begin
      res = {1'b1, {(N-1){1'b0}}};
    end else begin
      res = {1'b0, {(N-1){1'b1}}};
    end
    return {ovf, res};
  endfunction

  state_t        state_r, state_s;
  logic [N-1:0]  acc_r, acc_s;
  logic [CW-1:0] rem_r, rem_s;
  logic [N-1:0]  sum_r, sum_s;
  logic          sat_r, sat_s;
  logic          sum_valid_r;
  logic          msg_ready_r;
  logic          busy_r;
  logic [CW-1:0] deg_clip_s;
  logic [N:0]    add_s;
  logic          step_s;

  // Degree clamp and the shared adder.
  always_comb begin
    deg_clip_s = bus.deg;
    if (bus.deg > CW'(DMAX)) begin
      deg_clip_s = CW'(DMAX);
    end else begin
      deg_clip_s = bus.deg;
    end
    add_s = sat_add(acc_r, bus.msg);
  end

  // Next-state and datapath update.
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    rem_s   = rem_r;
    sum_s   = sum_r;
    sat_s   = sat_r;
    step_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          acc_s = bus.llr;
          sat_s = 1'b0;
          rem_s = deg_clip_s;
          if (deg_clip_s == {CW{1'b0}}) begin
            state_s = ST_OUT;
            sum_s   = bus.llr;
          end else begin
            state_s = ST_ACC;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (bus.msg_valid) begin
          step_s = 1'b1;
          acc_s  = add_s[N-1:0];
          sat_s  = sat_r | add_s[N];
          rem_s  = rem_r - CW'(1);
          if (rem_r == CW'(1)) begin
            state_s = ST_OUT;
            sum_s   = add_s[N-1:0];
          end else begin
            state_s = ST_ACC;
          end
        end else begin
          state_s = ST_ACC;
        end
      end
      ST_OUT: begin
        if (bus.sum_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_OUT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; handshake flags are decoded from the next state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r     <= ST_IDLE;
      acc_r       <= {N{1'b0}};
      rem_r       <= {CW{1'b0}};
      sum_r       <= {N{1'b0}};
      sat_r       <= 1'b0;
      sum_valid_r <= 1'b0;
      msg_ready_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      rem_r       <= rem_s;
      sum_r       <= sum_s;
      sat_r       <= sat_s;
      sum_valid_r <= (state_s == ST_OUT);
      msg_ready_r <= (state_s == ST_ACC);
      busy_r      <= (state_s != ST_IDLE);
    end
  end

`ifdef SAT_COUNT_EN
  logic [15:0] sat_cnt_r;

  // Lifetime count of clamped add steps, sticking at all-ones.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sat_cnt_r <= 16'd0;
    end else if (step_s && add_s[N] && (sat_cnt_r != 16'hFFFF)) begin
      sat_cnt_r <= sat_cnt_r + 16'd1;
    end else begin
      sat_cnt_r <= sat_cnt_r;
    end
  end

  assign bus.sat_cnt = sat_cnt_r;
`endif

  assign bus.msg_ready = msg_ready_r;
  assign bus.sum_valid = sum_valid_r;
  assign bus.sum       = sum_r;
  assign bus.sat       = sat_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_vn_sum_sequencer.sv
// Directed plus randomized bench for vn_sum_sequencer, checked against an integer clamp-per-step model.
module tb_vn_sum_sequencer;
  localparam int N    = 7;
  localparam int DMAX = 4;
  localparam int CW   = $clog2(DMAX + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   m_sat_cnt = 0;
  int   msg_buf [4];

  vn_sum_if #(.N(N), .DMAX(DMAX), .CW(CW)) bus ();

  vn_sum_sequencer #(.N(N), .DMAX(DMAX), .CW(CW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > 63) return 63;
    if (v < -64) return -64;
    return v;
  endfunction

  task automatic check_sat_cnt(input string tag);
`ifdef SAT_COUNT_EN
    check(tag, $signed({16'd0, bus.sat_cnt}), m_sat_cnt);
`endif
  endtask

  // gap < 0 picks a random 0..2 idle cycles before each message; poke pulses start while busy.
  task automatic run_op(input int llr, input int deg, input int gap, input int hold, input bit poke);
    int d, acc, s, g;
    bit exp_sat;
    logic [31:0] tmp;
    d = (deg > DMAX) ? DMAX : deg;
    acc = llr;
    exp_sat = 1'b0;
    for (int k = 0; k < d; k++) begin
      s = acc + msg_buf[k];
      if (s != clamp(s)) begin
        exp_sat = 1'b1;
        m_sat_cnt++;
      end
      acc = clamp(s);
    end
    tmp = llr;
    bus.start = 1'b1;
    bus.llr   = tmp[6:0];
    tmp = deg;
    bus.deg   = tmp[2:0];
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < d; k++) begin
      g = (gap < 0) ? int'($urandom_range(2)) : gap;
      for (int j = 0; j < g; j++) begin
        check("gap_ready", bus.msg_ready, 1);
        check("gap_valid", bus.sum_valid, 0);
        if (poke && j == 0) begin
          bus.start = 1'b1;
          bus.llr   = 7'd33;
          bus.deg   = 3'd0;
        end
        tick();
        bus.start = 1'b0;
      end
      check("acc_ready", bus.msg_ready, 1);
      check("acc_busy", bus.busy, 1);
      check("acc_valid", bus.sum_valid, 0);
      tmp = msg_buf[k];
      bus.msg_valid = 1'b1;
      bus.msg       = tmp[6:0];
      tick();
      bus.msg_valid = 1'b0;
    end
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", bus.sum_valid, 1);
      check("hold_sum", $signed(bus.sum), acc);
      check("hold_sat", bus.sat, exp_sat);
      check("hold_ready", bus.msg_ready, 0);
      if (poke) begin
        bus.start = 1'b1;
        bus.llr   = 7'd21;
        bus.deg   = 3'd2;
      end
      tick();
      bus.start = 1'b0;
    end
    check("out_valid", bus.sum_valid, 1);
    check("out_sum", $signed(bus.sum), acc);
    check("out_sat", bus.sat, exp_sat);
    check("out_busy", bus.busy, 1);
    check("out_ready", bus.msg_ready, 0);
    bus.sum_ready = 1'b1;
    bus.start     = poke;
    tick();
    bus.sum_ready = 1'b0;
    bus.start     = 1'b0;
    check("idle_valid", bus.sum_valid, 0);
    check("idle_busy", bus.busy, 0);
    check("idle_sat", bus.sat, exp_sat);
    check_sat_cnt("sat_cnt");
  endtask

  initial begin
    bus.start = 1'b0; bus.llr = 7'd0; bus.deg = 3'd0;
    bus.msg_valid = 1'b0; bus.msg = 7'd0; bus.sum_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", bus.sum_valid, 0);
    check("rst_sum", $signed(bus.sum), 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ready", bus.msg_ready, 0);
    check("rst_sat", bus.sat, 0);
    check_sat_cnt("rst_sat_cnt");
    rst_n = 1'b1;
    tick();

    msg_buf[0] = 5;   msg_buf[1] = -3;  msg_buf[2] = 20;
    run_op(10, 3, 0, 0, 1'b0);
    msg_buf[0] = 10;  msg_buf[1] = -10;
    run_op(60, 2, 0, 1, 1'b0);
    msg_buf[0] = -10;
    run_op(-60, 1, 0, 0, 1'b0);
    run_op(-7, 0, 0, 2, 1'b0);
    msg_buf[0] = 17;  msg_buf[1] = -30;
    run_op(4, 2, 3, 5, 1'b1);
    msg_buf[0] = 30;  msg_buf[1] = 30; msg_buf[2] = 30; msg_buf[3] = -50;
    run_op(1, 7, 0, 0, 1'b0);

    // Reset in the middle of an operation.
    bus.start = 1'b1; bus.llr = 7'd5; bus.deg = 3'd3;
    tick();
    bus.start = 1'b0;
    bus.msg_valid = 1'b1; bus.msg = 7'd4;
    tick();
    bus.msg_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    m_sat_cnt = 0;
    check("mid_rst_valid", bus.sum_valid, 0);
    check("mid_rst_sum", $signed(bus.sum), 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_ready", bus.msg_ready, 0);
    check("mid_rst_sat", bus.sat, 0);
    check_sat_cnt("mid_rst_sat_cnt");
    rst_n = 1'b1;
    tick();
    msg_buf[0] = 2;
    run_op(1, 1, 0, 0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < 4; k++) msg_buf[k] = int'($urandom_range(127)) - 64;
      run_op(int'($urandom_range(127)) - 64, int'($urandom_range(6)), -1,
             int'($urandom_range(3)), 1'($urandom_range(1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
